// File: rtl/vedic_div_16x8_pkg.sv
// rtl/vedic_div_16x8_pkg.sv - shared widths, iteration count and FSM state type for the divider
package vedic_pkg;

  localparam int DW        = 8;
  localparam int DIV_ITERS = 2 * DW;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/vedic_div_16x8_if.sv
// rtl/vedic_div_16x8_if.sv - operand and result valid/ready handshakes of the divider
interface vedic_div_16x8_if #(
  parameter int DW = vedic_pkg::DW
);

  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   a;
  logic [DW-1:0]     b;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   q;
  logic [DW-1:0]     r;
  logic              dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, dz
  );

endinterface

// File: rtl/vedic_div_step.sv
// rtl/vedic_div_step.sv - one combinational restoring-division iteration
module vedic_div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_next,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // One extra guard bit so the sign of the trial subtraction is explicit.
  assign shifted  = {rem, din};
  assign diff     = shifted - {2'b00, divisor};
  assign q_bit    = ~diff[DW+1];
  assign rem_next = q_bit ? diff[DW:0] : shifted[DW:0];

endmodule

// File: rtl/vedic_div_16x8.sv
// rtl/vedic_div_16x8.sv - iterative radix-2 restoring divider, 2*DW-bit dividend by DW-bit divisor
module vedic_div_16x8
  import vedic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  vedic_div_16x8_if.slave   io
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [DW:0]      rem;
  logic [2*DW-1:0]  quo;
  logic [DW-1:0]    div;
  logic             dz_q;
  logic             out_valid_q;
  logic [DW:0]      rem_next;
  logic             q_bit;

  vedic_div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .din      (quo[2*DW-1]),
    .divisor  (div),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      div         <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            div <= io.b;
            cnt <= CNT_W'(DIV_ITERS - 1);
            if (io.b == '0) begin
              // Divide-by-zero skips iteration and reports the dividend's low byte.
              quo         <= '1;
              rem         <= {1'b0, io.a[DW-1:0]};
              dz_q        <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              quo   <= io.a;
              rem   <= '0;
              dz_q  <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= {quo[2*DW-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.q         = quo;
  assign io.r         = rem[DW-1:0];
  assign io.dz        = dz_q;

endmodule

// File: tb/tb_vedic_div_16x8.sv
// tb/tb_vedic_div_16x8.sv - self-checking bench for vedic_div_16x8 against an arithmetic model
module tb_vedic_div_16x8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vedic_div_16x8_if bus ();

  vedic_div_16x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int          errors  = 0;
  int          checks  = 0;
  logic        pending = 1'b0;
  logic [15:0] exp_q   = '0;
  logic [7:0]  exp_r   = '0;
  logic        exp_dz  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] mq, output logic [7:0] mr, output logic mdz);
    if (b == 8'd0) begin
      mq  = 16'hFFFF;
      mr  = a[7:0];
      mdz = 1'b1;
    end else begin
      mq  = a / {8'd0, b};
      mr  = 8'(a % {8'd0, b});
      mdz = 1'b0;
    end
  endfunction

  // Whenever a result is presented it must match the model and stay frozen.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("out_valid_unexpected", {31'd0, pending}, 32'd1);
      check("q", {16'd0, bus.q}, {16'd0, exp_q});
      check("r", {24'd0, bus.r}, {24'd0, exp_r});
      check("dz", {31'd0, bus.dz}, {31'd0, exp_dz});
      check("in_ready_while_done", {31'd0, bus.in_ready}, 32'd0);
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int stall,
                       input bit noise, input bit lit, input logic [15:0] lq,
                       input logic [7:0] lr, input logic ldz);
    int w;
    int lat;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(a, b, exp_q, exp_r, exp_dz);
    pending = 1'b1;
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, (b == 8'd0) ? 32'd1 : 32'd17);
    if (lit) begin
      check("model_q_pin", {16'd0, exp_q}, {16'd0, lq});
      check("model_r_pin", {24'd0, exp_r}, {24'd0, lr});
      check("lit_q", {16'd0, bus.q}, {16'd0, lq});
      check("lit_r", {24'd0, bus.r}, {24'd0, lr});
      check("lit_dz", {31'd0, bus.dz}, {31'd0, ldz});
    end
    if (b != 8'd0) begin
      check("inv_eq", 32'(bus.q) * 32'(b) + 32'(bus.r), 32'(a));
      check("inv_lt", {31'd0, (bus.r < b)}, 32'd1);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (noise) begin
        bus.a        = ~a;
        bus.b        = b + 8'd3;
        bus.in_valid = 1'b1;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1 bus.out_ready = 1'b0;
    check("out_valid_fall", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_q", {16'd0, bus.q}, 32'd0);
    check("rst_r", {24'd0, bus.r}, 32'd0);
    check("rst_dz", {31'd0, bus.dz}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd65025, 8'd255, 0, 1'b0, 1'b1, 16'd255, 8'd0, 1'b0);
    do_op(16'd17408, 8'd128, 0, 1'b0, 1'b1, 16'd136, 8'd0, 1'b0);
    do_op(16'd100,   8'd7,   0, 1'b0, 1'b1, 16'd14,  8'd2, 1'b0);
    do_op(16'd8,     8'd2,   0, 1'b0, 1'b1, 16'd4,   8'd0, 1'b0);
    do_op(16'h1234,  8'd0,   0, 1'b0, 1'b1, 16'hFFFF, 8'h34, 1'b1);
    do_op(16'hFFFF,  8'd1,   0, 1'b0, 1'b1, 16'hFFFF, 8'd0, 1'b0);
    do_op(16'd0,     8'd9,   0, 1'b0, 1'b1, 16'd0,   8'd0, 1'b0);
    do_op(16'd1000,  8'd33,  10, 1'b1, 1'b1, 16'd30, 8'd10, 1'b0);

    // Reset pulse partway through iteration.
    @(negedge clk);
    bus.a        = 16'd1000;
    bus.b        = 8'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    model(16'd1000, 8'd7, exp_q, exp_r, exp_dz);
    pending = 1'b1;
    #1 bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    pending = 1'b0;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_q", {16'd0, bus.q}, 32'd0);
    check("midrst_r", {24'd0, bus.r}, 32'd0);
    check("midrst_dz", {31'd0, bus.dz}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd48, 8'd8, 0, 1'b0, 1'b1, 16'd6, 8'd0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_op(ra, rb, $urandom_range(0, 3), 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
